xor_serial_scheduler: RTL and testbench

- Shares one external single-bit Xor gate between two requesters.
- Each requester submits a W-bit operand pair over a valid/ready handshake.
- The block arbitrates round-robin, streams the pair through the gate one bit per cycle (LSB first), and assembles the W-bit result.
- It returns the result on a response handshake, tagged with the requester id.
- It sits between the Xor gate instance and any sequential logic needing wide XOR without replicating gates.

---
 rtl/xor_serial_scheduler.sv | 142 ++++++++++++++
 tb/tb_xor_serial_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_serial_scheduler.sv
// xor_serial_scheduler: shares one external 1-bit XOR gate between two
// requesters. Round-robin grant, bit-serial LSB-first evaluation of a W-bit
// operand pair, result returned on a response handshake tagged with the id.
module xor_serial_scheduler #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0Valid,
  output logic         req0Ready,
  input  logic [W-1:0] req0A,
  input  logic [W-1:0] req0B,
  input  logic         req1Valid,
  output logic         req1Ready,
  input  logic [W-1:0] req1A,
  input  logic [W-1:0] req1B,
  output logic         respValid,
  input  logic         respReady,
  output logic         respId,
  output logic [W-1:0] respOut,
  output logic         xorInA,
  output logic         xorInB,
  input  logic         xorOut
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [W-1:0]  result_q, result_d;
  logic          resp_id_q, resp_id_d;
  logic          last_grant_q, last_grant_d;

  logic          grant_vld_c;
  logic          grant_id_c;
  logic          ready0_c;
  logic          ready1_c;
  logic          xor_a_c;
  logic          xor_b_c;

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      resp_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      resp_id_q    <= resp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state, round-robin grant and gate drive
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    resp_id_d    = resp_id_q;
    last_grant_d = last_grant_q;
    grant_vld_c  = 1'b0;
    grant_id_c   = 1'b0;
    ready0_c     = 1'b0;
    ready1_c     = 1'b0;
    xor_a_c      = 1'b0;
    xor_b_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0Valid && req1Valid) begin
          grant_vld_c = 1'b1;
          grant_id_c  = ~last_grant_q;
        end else if (req0Valid) begin
          grant_vld_c = 1'b1;
          grant_id_c  = 1'b0;
        end else if (req1Valid) begin
          grant_vld_c = 1'b1;
          grant_id_c  = 1'b1;
        end
        ready0_c = grant_vld_c & ~grant_id_c;
        ready1_c = grant_vld_c & grant_id_c;
        // Ready is only offered to a valid requester, so a grant is a handshake
        if (grant_vld_c) begin
          op_a_d       = grant_id_c ? req1A : req0A;
          op_b_d       = grant_id_c ? req1B : req0B;
          resp_id_d    = grant_id_c;
          last_grant_d = grant_id_c;
          bit_cnt_d    = '0;
          result_d     = '0;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        xor_a_c             = op_a_q[bit_cnt_q];
        xor_b_c             = op_b_q[bit_cnt_q];
        result_d[bit_cnt_q] = xorOut;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (respReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ready strobes are masked by reset so nothing is offered while held in reset
  assign req0Ready = ready0_c & rst_n;
  assign req1Ready = ready1_c & rst_n;
  assign xorInA    = xor_a_c;
  assign xorInB    = xor_b_c;
  assign respValid = (state_q == ST_DONE);
  assign respOut   = result_q;
  assign respId    = resp_id_q;

endmodule

// File: tb/tb_xor_serial_scheduler.sv
// Directed bench for xor_serial_scheduler: reset, arbitration, latency,
// backpressure, gate-path trace, mid-operation reset and a fairness soak.
module tb_xor_serial_scheduler;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0Valid, req1Valid;
  logic         req0Ready, req1Ready;
  logic [W-1:0] req0A, req0B, req1A, req1B;
  logic         respValid, respReady, respId;
  logic [W-1:0] respOut;
  logic         xorInA, xorInB, xorOut;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External single-bit gate model
  assign xorOut = xorInA ^ xorInB;

  xor_serial_scheduler #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0Valid (req0Valid),
    .req0Ready (req0Ready),
    .req0A     (req0A),
    .req0B     (req0B),
    .req1Valid (req1Valid),
    .req1Ready (req1Ready),
    .req1A     (req1A),
    .req1B     (req1B),
    .respValid (respValid),
    .respReady (respReady),
    .respId    (respId),
    .respOut   (respOut),
    .xorInA    (xorInA),
    .xorInB    (xorInB),
    .xorOut    (xorOut)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from a single requester with respReady high; ends in DONE
  task automatic do_txn(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_out, input string tag);
    logic [W-1:0] tr_a;
    logic [W-1:0] tr_b;
    int           noisy;
    tr_a  = '0;
    tr_b  = '0;
    noisy = 0;
    @(negedge clk);
    if (id) begin
      req1Valid = 1'b1; req1A = a; req1B = b;
    end else begin
      req0Valid = 1'b1; req0A = a; req0B = b;
    end
    respReady = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'({req1Ready, req0Ready}), id ? 64'd2 : 64'd1);
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      #1;
      tr_a[k] = xorInA;
      tr_b[k] = xorInB;
      if (respValid || req0Ready || req1Ready) noisy++;
    end
    chk({tag, "_shift_quiet"}, 64'(noisy), 64'd0);
    chk({tag, "_trace_a"}, 64'(tr_a), 64'(a));
    chk({tag, "_trace_b"}, 64'(tr_b), 64'(b));
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 64'(respValid), 64'd1);
    chk({tag, "_out"}, 64'(respOut), 64'(exp_out));
    chk({tag, "_id"}, 64'(respId), 64'(id));
    chk({tag, "_gate_done"}, 64'({xorInA, xorInB}), 64'd0);
  endtask

  logic [W-1:0] q_out[$];
  logic         q_id[$];
  logic [W-1:0] exp_o;
  logic         exp_i;
  logic         exp_grant;
  logic         upd0, upd1;
  int           bad;
  int           n_resp;
  int           cyc;

  initial begin
    // Reset with both requesters already valid
    rst_n     = 1'b0;
    req0Valid = 1'b1; req0A = 16'hFFFF; req0B = 16'h0000;
    req1Valid = 1'b1; req1A = 16'h1234; req1B = 16'h1234;
    respReady = 1'b1;
    #3;
    chk("rst_ctrl", 64'({req0Ready, req1Ready, respValid, xorInA, xorInB, respId}), 64'd0);
    chk("rst_out", 64'(respOut), 64'd0);

    // Simultaneous requests out of reset: 0 first, then 1
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sim_grant0", 64'({req1Ready, req0Ready}), 64'd1);
    bad = 0;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      req0Valid = 1'b0;
      #1;
      if (respValid || req0Ready || req1Ready) bad++;
    end
    chk("sim_shift0_quiet", 64'(bad), 64'd0);
    @(negedge clk);
    #1;
    chk("sim_resp0", 64'({respValid, respId, req1Ready}), 64'b100);
    chk("sim_out0", 64'(respOut), 64'hFFFF);
    @(negedge clk);
    #1;
    chk("sim_grant1", 64'({respValid, req1Ready}), 64'b01);
    bad = 0;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      req1Valid = 1'b0;
      #1;
      if (respValid || req0Ready || req1Ready) bad++;
    end
    chk("sim_shift1_quiet", 64'(bad), 64'd0);
    @(negedge clk);
    #1;
    chk("sim_resp1", 64'({respValid, respId}), 64'b11);
    chk("sim_out1", 64'(respOut), 64'h0000);

    // Single request latency and result
    do_txn(1'b0, 16'hA5F0, 16'h0FF0, 16'hAA00, "single");
    @(negedge clk);
    #1;
    chk("idle_hold", 64'({respValid, respOut}), 64'h0AA00);

    // Gate-path trace: A bit only in cycle 0, B bit only in cycle 15
    do_txn(1'b1, 16'h0001, 16'h8000, 16'h8001, "gate");

    // Backpressure on the response
    @(negedge clk);
    req1Valid = 1'b1; req1A = 16'h00FF; req1B = 16'h0F0F;
    respReady = 1'b0;
    #1;
    chk("bp_grant", 64'({req1Ready, req0Ready}), 64'd2);
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      req1Valid = 1'b0;
      #1;
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req0Valid = 1'b1; req0A = 16'hFF00; req0B = 16'h00FF;
      respReady = 1'b0;
      #1;
      if (!respValid || respOut !== 16'h0FF0 || respId !== 1'b1 || req0Ready || req1Ready) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    @(negedge clk);
    respReady = 1'b1;
    #1;
    chk("bp_6th", 64'({respValid, respOut, respId}), {47'd0, 1'b1, 16'h0FF0, 1'b1} >> 0);
    @(negedge clk);
    #1;
    chk("bp_idle_grant", 64'({respValid, req1Ready, req0Ready}), 64'b001);
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      req0Valid = 1'b0;
      #1;
    end
    @(negedge clk);
    #1;
    chk("bp_next_resp", 64'({respValid, respId, respOut}), {46'd0, 2'b10, 16'hFFFF});

    // Asynchronous reset in SHIFT cycle 7
    @(negedge clk);
    req0Valid = 1'b1; req0A = 16'hFFFF; req0B = 16'h0F0F;
    #1;
    chk("mrst_grant", 64'({req1Ready, req0Ready}), 64'd1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req0Valid = 1'b0;
      #1;
    end
    @(negedge clk);
    #1;
    chk("mrst_pre_gate", 64'({xorInA, xorInB}), 64'b10);
    #2;
    req0Valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("mrst_ctrl", 64'({req0Ready, req1Ready, respValid, xorInA, xorInB, respId}), 64'd0);
    chk("mrst_out", 64'(respOut), 64'd0);
    @(negedge clk);
    req0Valid = 1'b0;
    rst_n     = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (respValid) bad++;
    end
    chk("mrst_no_resp", 64'(bad), 64'd0);
    do_txn(1'b0, 16'h3C3C, 16'h5A5A, 16'h6666, "post_rst");

    // Fairness soak: both always valid, random operands and response stalls
    req0A = 16'($urandom); req0B = 16'($urandom);
    req1A = 16'($urandom); req1B = 16'($urandom);
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    exp_grant = 1'b1;
    upd0 = 1'b0; upd1 = 1'b0;
    n_resp = 0;
    cyc = 0;
    while (n_resp < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (upd0) begin req0A = 16'($urandom); req0B = 16'($urandom); upd0 = 1'b0; end
      if (upd1) begin req1A = 16'($urandom); req1B = 16'($urandom); upd1 = 1'b0; end
      respReady = ($urandom_range(0, 3) != 0);
      #1;
      if (req0Ready || req1Ready) begin
        chk("soak_grant", 64'({req1Ready, req0Ready}), exp_grant ? 64'd2 : 64'd1);
        if (exp_grant) begin
          q_out.push_back(req1A ^ req1B); q_id.push_back(1'b1); upd1 = 1'b1;
        end else begin
          q_out.push_back(req0A ^ req0B); q_id.push_back(1'b0); upd0 = 1'b1;
        end
        exp_grant = ~exp_grant;
      end
      if (respValid && respReady) begin
        chk("soak_inflight", 64'(q_out.size()), 64'd1);
        if (q_out.size() != 0) begin
          exp_o = q_out.pop_front();
          exp_i = q_id.pop_front();
          chk("soak_out", 64'(respOut), 64'(exp_o));
          chk("soak_id", 64'(respId), 64'(exp_i));
        end
        n_resp++;
      end
    end
    chk("soak_count", 64'(n_resp), 64'd200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
